// File: rtl/booth_accum.sv
// booth_accum: signed saturating group accumulator behind the radix-4 Booth multiplier.
// Sums groups of len products (0 means 16) into a saturating ACC_W-bit result and presents
// each finished sum on a valid/ready port. No product is accepted while a result is held.
//
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   clr                synchronous abort of the group in progress or the held result
//   len[3:0]           products per group, sampled on the first product of a group
//   prod_valid/ready   product handshake, prod[7:0] signed
//   acc_valid/ready    result handshake, acc_data[ACC_W-1:0] signed, acc_sat saturation flag
module booth_accum #(
  parameter int unsigned ACC_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  input  logic [3:0]       len,
  input  logic             prod_valid,
  input  logic [7:0]       prod,
  output logic             prod_ready,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic [ACC_W-1:0] acc_data,
  output logic             acc_sat
);

  typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

  localparam logic [ACC_W-1:0] AccMax = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] AccMin = {1'b1, {(ACC_W-1){1'b0}}};

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             sat_q, sat_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [4:0]       lim_q, lim_d;

  logic [ACC_W-1:0] prod_sext;
  logic [ACC_W:0]   sum_wide;
  logic [ACC_W-1:0] add_res;
  logic             add_sat;

  // Saturating add: one guard bit exposes overflow as a mismatch of the top two sum bits.
  always_comb begin
    prod_sext = {{(ACC_W-8){prod[7]}}, prod};
    sum_wide  = {acc_q[ACC_W-1], acc_q} + {prod_sext[ACC_W-1], prod_sext};
    add_res   = sum_wide[ACC_W-1:0];
    add_sat   = 1'b0;
    if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
      add_sat = 1'b1;
      add_res = sum_wide[ACC_W] ? AccMin : AccMax;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      acc_q   <= '0;
      sat_q   <= 1'b0;
      cnt_q   <= '0;
      lim_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
      cnt_q   <= cnt_d;
      lim_q   <= lim_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sat_d   = sat_q;
    cnt_d   = cnt_q;
    lim_d   = lim_q;
    if (clr) begin
      // Abort wins over any simultaneous transfer; a product offered now is dropped.
      state_d = StIdle;
      acc_d   = '0;
      sat_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (prod_valid) begin
            acc_d   = prod_sext;
            sat_d   = 1'b0;
            lim_d   = (len == 4'd0) ? 5'd16 : {1'b0, len};
            cnt_d   = 5'd1;
            state_d = (lim_d == 5'd1) ? StHold : StAccum;
          end
        end
        StAccum: begin
          if (prod_valid) begin
            acc_d = add_res;
            sat_d = sat_q | add_sat;
            cnt_d = cnt_q + 5'd1;
            if (cnt_d == lim_q) state_d = StHold;
          end
        end
        StHold: begin
          if (acc_ready) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    prod_ready = (state_q != StHold);
    acc_valid  = (state_q == StHold);
    acc_data   = acc_q;
    acc_sat    = sat_q;
  end

endmodule

// File: tb/tb_booth_accum.sv
// Self-checking bench for booth_accum. Two instances (ACC_W=16 and ACC_W=9) share one
// stimulus stream; a group-level reference model predicts every output every cycle.
module tb_booth_accum;

  logic        clk;
  logic        resetn;
  logic        clr;
  logic [3:0]  len;
  logic        prod_valid;
  logic [7:0]  prod;
  logic        acc_ready;

  logic        prod_ready16, acc_valid16, acc_sat16;
  logic [15:0] acc_data16;
  logic        prod_ready9, acc_valid9, acc_sat9;
  logic [8:0]  acc_data9;

  int n_checks = 0;
  int n_errors = 0;

  booth_accum #(.ACC_W(16)) u_dut16 (
    .clk        (clk),
    .resetn     (resetn),
    .clr        (clr),
    .len        (len),
    .prod_valid (prod_valid),
    .prod       (prod),
    .prod_ready (prod_ready16),
    .acc_valid  (acc_valid16),
    .acc_ready  (acc_ready),
    .acc_data   (acc_data16),
    .acc_sat    (acc_sat16)
  );

  booth_accum #(.ACC_W(9)) u_dut9 (
    .clk        (clk),
    .resetn     (resetn),
    .clr        (clr),
    .len        (len),
    .prod_valid (prod_valid),
    .prod       (prod),
    .prod_ready (prod_ready9),
    .acc_valid  (acc_valid9),
    .acc_ready  (acc_ready),
    .acc_data   (acc_data9),
    .acc_sat    (acc_sat9)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: products of the open group, whether a result is held, and the
  // accumulator value left behind once no group is open.
  int grp[$];
  int m_lim;
  bit m_hold;
  int m_acc16, m_acc9;
  bit m_sat16, m_sat9;
  int n_out;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void group_sum(input int w, output int s, output bit st);
    int hi, lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    s  = 0;
    st = 1'b0;
    foreach (grp[i]) begin
      s = s + grp[i];
      if (s > hi) begin
        s  = hi;
        st = 1'b1;
      end else if (s < lo) begin
        s  = lo;
        st = 1'b1;
      end
    end
  endfunction

  function automatic void model_reset();
    grp.delete();
    m_hold  = 1'b0;
    m_lim   = 0;
    m_acc16 = 0;
    m_acc9  = 0;
    m_sat16 = 1'b0;
    m_sat9  = 1'b0;
  endfunction

  task automatic check_outputs(input string tag);
    int e16, e9;
    bit s16, s9;
    if (grp.size() > 0) begin
      group_sum(16, e16, s16);
      group_sum(9, e9, s9);
    end else begin
      e16 = m_acc16;
      s16 = m_sat16;
      e9  = m_acc9;
      s9  = m_sat9;
    end
    check_eq({tag, ".prod_ready16"}, int'(prod_ready16), int'(!m_hold));
    check_eq({tag, ".acc_valid16"}, int'(acc_valid16), int'(m_hold));
    check_eq({tag, ".acc_data16"}, int'($signed(acc_data16)), e16);
    check_eq({tag, ".acc_sat16"}, int'(acc_sat16), int'(s16));
    check_eq({tag, ".prod_ready9"}, int'(prod_ready9), int'(!m_hold));
    check_eq({tag, ".acc_valid9"}, int'(acc_valid9), int'(m_hold));
    check_eq({tag, ".acc_data9"}, int'($signed(acc_data9)), e9);
    check_eq({tag, ".acc_sat9"}, int'(acc_sat9), int'(s9));
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then check.
  task automatic cycle(input string tag, input bit pv, input int p, input int l,
                       input bit ar, input bit c);
    logic [7:0] pb;
    pb         = p[7:0];
    prod_valid = pv;
    prod       = pb;
    len        = l[3:0];
    acc_ready  = ar;
    clr        = c;
    if (c) begin
      grp.delete();
      m_hold  = 1'b0;
      m_acc16 = 0;
      m_acc9  = 0;
      m_sat16 = 1'b0;
      m_sat9  = 1'b0;
    end else if (m_hold) begin
      if (ar) begin
        group_sum(16, m_acc16, m_sat16);
        group_sum(9, m_acc9, m_sat9);
        grp.delete();
        m_hold = 1'b0;
        n_out++;
      end
    end else if (pv) begin
      if (grp.size() == 0) m_lim = (l[3:0] == 4'd0) ? 16 : int'(l[3:0]);
      grp.push_back(int'($signed(pb)));
      if (grp.size() == m_lim) m_hold = 1'b1;
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic idle(input string tag, input int n, input bit ar);
    for (int i = 0; i < n; i++) cycle(tag, 1'b0, 0, 0, ar, 1'b0);
  endtask

  initial begin
    int outs_before;
    resetn     = 1'b0;
    clr        = 1'b0;
    len        = '0;
    prod_valid = 1'b0;
    prod       = '0;
    acc_ready  = 1'b0;
    n_out      = 0;
    model_reset();
    #12;
    check_outputs("reset");
    resetn = 1'b1;

    // Basic group: 5 - 3 + 10 = 12, held until acc_ready.
    cycle("basic", 1'b1, 5, 3, 1'b0, 1'b0);
    cycle("basic", 1'b1, -3, 3, 1'b0, 1'b0);
    cycle("basic", 1'b1, 10, 3, 1'b0, 1'b0);
    check_eq("basic_valid", int'(acc_valid16), 1);
    check_eq("basic_sum", int'($signed(acc_data16)), 12);
    idle("basic_hold", 2, 1'b0);
    cycle("basic_take", 1'b0, 0, 0, 1'b1, 1'b0);

    // Saturation on the 9-bit instance, positive then negative.
    cycle("satp", 1'b1, 100, 4, 1'b0, 1'b0);
    cycle("satp", 1'b1, 100, 4, 1'b0, 1'b0);
    cycle("satp", 1'b1, 100, 4, 1'b0, 1'b0);
    check_eq("satp_clamp9", int'($signed(acc_data9)), 255);
    check_eq("satp_flag9", int'(acc_sat9), 1);
    cycle("satp", 1'b1, -128, 4, 1'b0, 1'b0);
    check_eq("satp_final9", int'($signed(acc_data9)), 127);
    cycle("satp_take", 1'b0, 0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle("satn", 1'b1, -128, 4, 1'b0, 1'b0);
    check_eq("satn_final9", int'($signed(acc_data9)), -256);
    check_eq("satn_flag9", int'(acc_sat9), 1);
    cycle("satn_take", 1'b0, 0, 0, 1'b1, 1'b0);

    // len=0 means 16: prod_ready stays high through exactly 16 transfers.
    for (int i = 0; i < 16; i++) cycle("len16", 1'b1, -128, 0, 1'b0, 1'b0);
    check_eq("len16_sum", int'($signed(acc_data16)), -2048);
    check_eq("len16_sat", int'(acc_sat16), 0);
    cycle("len16_take", 1'b0, 0, 0, 1'b1, 1'b0);

    // Gaps, a len change mid-group, and back-pressure on the result.
    outs_before = n_out;
    cycle("gap", 1'b1, 7, 2, 1'b0, 1'b0);
    cycle("gap", 1'b0, 0, 5, 1'b0, 1'b0);
    cycle("gap", 1'b0, 0, 5, 1'b0, 1'b0);
    cycle("gap", 1'b0, 0, 5, 1'b0, 1'b0);
    cycle("gap", 1'b1, 1, 5, 1'b0, 1'b0);
    idle("gap_hold", 5, 1'b0);
    check_eq("gap_sum", int'($signed(acc_data16)), 8);
    cycle("gap_take", 1'b0, 0, 0, 1'b1, 1'b0);
    idle("gap_after", 2, 1'b1);
    check_eq("gap_single_out", n_out - outs_before, 1);

    // clr mid-group with a product offered in the same cycle.
    cycle("clr", 1'b1, 20, 4, 1'b0, 1'b0);
    cycle("clr", 1'b1, 20, 4, 1'b0, 1'b0);
    cycle("clr", 1'b1, 20, 4, 1'b1, 1'b1);
    cycle("clr_new", 1'b1, -9, 1, 1'b0, 1'b0);
    check_eq("clr_sum", int'($signed(acc_data16)), -9);
    cycle("clr_take", 1'b0, 0, 0, 1'b1, 1'b0);

    // Asynchronous reset while holding a result.
    cycle("rst", 1'b1, 33, 1, 1'b0, 1'b0);
    #2;
    resetn = 1'b0;
    #1;
    model_reset();
    check_outputs("rst_async");
    #2;
    resetn = 1'b1;
    cycle("rst_next", 1'b1, 50, 2, 1'b0, 1'b0);
    cycle("rst_next", 1'b1, -7, 2, 1'b0, 1'b0);
    check_eq("rst_next_sum", int'($signed(acc_data16)), 43);
    cycle("rst_take", 1'b0, 0, 0, 1'b1, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      cycle("rand", ($urandom_range(0, 9) < 7), int'($urandom_range(0, 255)) - 128,
            int'($urandom_range(0, 15)), ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 99) < 3));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
